// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: accepts parallel words over valid/ready, shifts them
// out one bit per clock with optional inter-word gap, flags 1111/1001 windows.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-low reset
//   in_data    word to transmit (WIDTH bits)
//   in_valid   in_data valid
//   in_ready   word accepted on cycle where in_valid & in_ready
//   out        registered serial bit
//   out_valid  out carries a data bit this cycle
//   hit        out_valid & last 4 emitted bits == 1111 or 1001
//   done       pulse on the cycle carrying a word's last bit

module seq_pattern_tx #(
    parameter int   WIDTH     = 8,
    parameter int   GAP       = 0,
    parameter int   MSB_FIRST = 1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out,
    output logic             out_valid,
    output logic             hit,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;
    localparam logic [CW-1:0] LAST  = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GLAST = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic [GW-1:0]    gcnt;
    logic [2:0]       hist;
    logic             out_q;
    logic             last;
    logic             hs;
    logic             load;
    logic             adv;
    logic             first_bit;
    logic             next_bit;

    // sreg holds the bits not yet on 'out', aligned so the next one
    // sits at the end that is transmitted first.
    function automatic logic [WIDTH-1:0] shl(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
    endfunction

    assign last      = (cnt == LAST);
    assign first_bit = (MSB_FIRST != 0) ? in_data[WIDTH-1] : in_data[0];
    assign next_bit  = (MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0];
    assign hs        = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        load      = 1'b0;
        adv       = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        unique case (state)
            S_IDLE: begin
                in_ready = rst;
                if (hs) begin
                    load    = 1'b1;
                    state_n = S_SHIFT;
                end
            end
            S_SHIFT: begin
                out_valid = 1'b1;
                done      = last;
                in_ready  = rst & last & (GAP == 0);
                if (!last) begin
                    adv = 1'b1;
                end else if (hs) begin
                    load = 1'b1;
                end else if (GAP != 0) begin
                    state_n = S_GAP;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_GAP: begin
                if (gcnt == GLAST) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg  <= '0;
            cnt   <= '0;
            gcnt  <= '0;
            hist  <= 3'b000;
            out_q <= IDLE_BIT;
        end else begin
            // only real data bits enter the history
            if (out_valid) begin
                hist <= {hist[1:0], out_q};
            end
            if (load) begin
                sreg  <= shl(in_data);
                out_q <= first_bit;
                cnt   <= '0;
            end else if (adv) begin
                sreg  <= shl(sreg);
                out_q <= next_bit;
                cnt   <= cnt + 1'b1;
            end else begin
                out_q <= IDLE_BIT;
                cnt   <= '0;
            end
            if (state == S_GAP && state_n == S_GAP) begin
                gcnt <= gcnt + 1'b1;
            end else begin
                gcnt <= '0;
            end
        end
    end

    assign out = out_q;
    assign hit = out_valid &
                 (({hist, out_q} == 4'b1111) || ({hist, out_q} == 4'b1001));

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: three instances cover the default
// configuration, a two-cycle gap, and LSB-first ordering.

module tb_seq_pattern_tx;

    logic       clk = 1'b0;
    logic       rst;

    logic [7:0] d0, d1, d2;
    logic       v0, v1, v2;
    logic       r0, r1, r2;
    logic       o0, o1, o2;
    logic       ov0, ov1, ov2;
    logic       h0, h1, h2;
    logic       dn0, dn1, dn2;

    int total  = 0;
    int passed = 0;

    logic [7:0]  eb8;
    logic [7:0]  eh8;
    logic [15:0] eb16;
    logic [15:0] eh16;

    always #5 clk = ~clk;

    seq_pattern_tx #(.WIDTH(8), .GAP(0), .MSB_FIRST(1), .IDLE_BIT(1'b0)) u0 (
        .clk(clk), .rst(rst), .in_data(d0), .in_valid(v0), .in_ready(r0),
        .out(o0), .out_valid(ov0), .hit(h0), .done(dn0)
    );

    seq_pattern_tx #(.WIDTH(8), .GAP(2), .MSB_FIRST(1), .IDLE_BIT(1'b0)) u1 (
        .clk(clk), .rst(rst), .in_data(d1), .in_valid(v1), .in_ready(r1),
        .out(o1), .out_valid(ov1), .hit(h1), .done(dn1)
    );

    seq_pattern_tx #(.WIDTH(8), .GAP(0), .MSB_FIRST(0), .IDLE_BIT(1'b0)) u2 (
        .clk(clk), .rst(rst), .in_data(d2), .in_valid(v2), .in_ready(r2),
        .out(o2), .out_valid(ov2), .hit(h2), .done(dn2)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // reset held with in_valid asserted
        rst = 1'b0;
        d0 = 8'hFF; d1 = 8'hFF; d2 = 8'hFF;
        v0 = 1'b1;  v1 = 1'b1;  v2 = 1'b1;
        repeat (3) tick();
        chk("rst_in_ready", r0, 1'b0);
        chk("rst_out", o0, 1'b0);
        chk("rst_out_valid", ov0, 1'b0);
        chk("rst_hit", h0, 1'b0);
        chk("rst_done", dn0, 1'b0);
        chk("rst_in_ready_u1", r1, 1'b0);
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        rst = 1'b1;
        #1;
        chk("rel_in_ready", r0, 1'b1);

        // single word, MSB first: 1001_1110
        d0 = 8'b1001_1110; v0 = 1'b1;
        eb8 = 8'b1001_1110;
        eh8 = 8'b0001_0010;
        tick();
        v0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("w1_out%0d", i + 1), o0, eb8[7-i]);
            chk($sformatf("w1_ov%0d", i + 1), ov0, 1'b1);
            chk($sformatf("w1_hit%0d", i + 1), h0, eh8[7-i]);
            chk($sformatf("w1_done%0d", i + 1), dn0, i == 7);
            tick();
        end
        chk("w1_idle_ov", ov0, 1'b0);
        chk("w1_idle_rdy", r0, 1'b1);

        // back-to-back FF then 0F, history 110 carried over
        d0 = 8'hFF; v0 = 1'b1;
        eb16 = 16'b1111_1111_0000_1111;
        eh16 = 16'b0001_1111_0000_0001;
        tick();
        d0 = 8'h0F;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("bb_out%0d", i + 1), o0, eb16[15-i]);
            chk($sformatf("bb_ov%0d", i + 1), ov0, 1'b1);
            chk($sformatf("bb_hit%0d", i + 1), h0, eh16[15-i]);
            chk($sformatf("bb_done%0d", i + 1), dn0, (i == 7) || (i == 15));
            if (i == 0) chk("bb_rdy_mid", r0, 1'b0);
            if (i == 7) chk("bb_rdy_last", r0, 1'b1);
            if (i == 8) v0 = 1'b0;
            tick();
        end
        chk("bb_idle_ov", ov0, 1'b0);

        // GAP=2 instance: A5 then 3C
        d1 = 8'hA5; v1 = 1'b1;
        eb8 = 8'hA5;
        tick();
        d1 = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("g_out%0d", i + 1), o1, eb8[7-i]);
            chk($sformatf("g_done%0d", i + 1), dn1, i == 7);
            tick();
        end
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("g_gap_ov%0d", g), ov1, 1'b0);
            chk($sformatf("g_gap_out%0d", g), o1, 1'b0);
            chk($sformatf("g_gap_rdy%0d", g), r1, 1'b0);
            tick();
        end
        chk("g_rdy_rise", r1, 1'b1);
        tick();
        v1 = 1'b0;
        chk("g_w2_ov", ov1, 1'b1);
        chk("g_w2_out1", o1, 1'b0);
        tick();
        chk("g_w2_out2", o1, 1'b0);
        tick();
        chk("g_w2_out3", o1, 1'b1);
        repeat (8) tick();

        // LSB-first instance: 0000_1001
        d2 = 8'b0000_1001; v2 = 1'b1;
        eb8 = 8'b1001_0000;
        eh8 = 8'b0001_0000;
        tick();
        v2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("lsb_out%0d", i + 1), o2, eb8[7-i]);
            chk($sformatf("lsb_hit%0d", i + 1), h2, eh8[7-i]);
            chk($sformatf("lsb_done%0d", i + 1), dn2, i == 7);
            tick();
        end

        // reset pulse at bit 5 of a word
        d0 = 8'hFF; v0 = 1'b1;
        tick();
        v0 = 1'b0;
        repeat (4) tick();
        chk("mid_ov_pre", ov0, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_ov", ov0, 1'b0);
        chk("mid_rst_out", o0, 1'b0);
        chk("mid_rst_hit", h0, 1'b0);
        chk("mid_rst_done", dn0, 1'b0);
        chk("mid_rst_rdy", r0, 1'b0);
        tick();
        rst = 1'b1;
        d0 = 8'h90; v0 = 1'b1;
        eb8 = 8'b1001_0000;
        eh8 = 8'b0001_0000;
        tick();
        v0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("post_out%0d", i + 1), o0, eb8[7-i]);
            chk($sformatf("post_hit%0d", i + 1), h0, eh8[7-i]);
            chk($sformatf("post_done%0d", i + 1), dn0, i == 7);
            tick();
        end
        chk("post_idle_ov", ov0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
